adder_sequencer: RTL and testbench
==================================

Name: adder_sequencer

Overview:
- AXI4-Lite master that sequences one transaction on the memory-mapped adder slave.
- Each transaction writes operand A, writes operand B, reads the sum, then reads the overflow flag.
- Shares the single adder between two requesters using round-robin arbitration.
- Returns sum, overflow and error status to the granted requester as a one-cycle response pulse.

Parameters:
DATA_WIDTH, 32, operand/sum/AXI data width
ADDR_WIDTH, 8, AXI address width
RESP_WIDTH, 3, width of bresp/rresp
BASE_ADDR, 0, adder base address; register offsets are added to it
TIMEOUT_CYCLES, 255, max cycles waited in any single bus phase before abort

Ports:
m1_axi_aclk  in  1  single clock
m1_axi_aresetn  in  1  synchronous active-low reset
req_valid  in  2  per-requester operation request
req_ready  out  2  one-hot, one-cycle pulse: request accepted, operands latched
req_a  in  2*DATA_WIDTH  operand A; requester i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
req_b  in  2*DATA_WIDTH  operand B; same slicing as req_a
rsp_valid  out  2  one-hot, one-cycle pulse to the owning requester
rsp_sum  out  DATA_WIDTH  sum as read from the slave
rsp_ovf  out  1  overflow flag (bit 0 of the overflow read)
rsp_err  out  1  transaction aborted (bad response or timeout)
m1_axi_awaddr  out  ADDR_WIDTH  write address
m1_axi_awvalid  out  1  write address valid
m1_axi_awready  in  1  write address ready
m1_axi_wdata  out  DATA_WIDTH  write data
m1_axi_wstrb  out  DATA_WIDTH/8  write strobes, always all ones
m1_axi_wvalid  out  1  write data valid
m1_axi_wready  in  1  write data ready
m1_axi_bresp  in  RESP_WIDTH  write response
m1_axi_bvalid  in  1  write response valid
m1_axi_bready  out  1  write response ready
m1_axi_araddr  out  ADDR_WIDTH  read address
m1_axi_arvalid  out  1  read address valid
m1_axi_arready  in  1  read address ready
m1_axi_rdata  in  DATA_WIDTH  read data
m1_axi_rresp  in  RESP_WIDTH  read response
m1_axi_rvalid  in  1  read data valid
m1_axi_rready  out  1  read data ready

Behaviour:
- Clock and reset: single clock m1_axi_aclk; reset m1_axi_aresetn is synchronous, active-low.
- Reset values: all outputs registered; reset drives every valid/ready/rsp output to 0, addresses/data to 0, FSM to IDLE, last_grant to 1 (so requester 0 wins first).
- FSM states: IDLE -> WR_A -> WR_B -> RD_SUM -> RD_OVF -> RESP -> IDLE.
- IDLE: if any req_valid, grant via round-robin.
  - Simultaneous requests: the requester not granted last wins.
  - On grant: pulse req_ready for that requester, latch its A/B and owner id, update last_grant.
- Write phases (WR_A at BASE_ADDR+0, WR_B at BASE_ADDR+4):
  - Assert awvalid, wvalid and bready together on phase entry.
  - Drop awvalid on the edge after awvalid&&awready is sampled; same for wvalid/wready, tracked independently.
  - bvalid may arrive in the same cycle as awready/wready or later; accept either.
  - Phase completes when both address and data handshakes are done and bvalid has been seen.
  - On completion, drop bready.
- Read phases (RD_SUM at BASE_ADDR+8, RD_OVF at BASE_ADDR+12):
  - Assert arvalid and rready together.
  - Drop arvalid after the arvalid&&arready handshake.
  - rvalid may coincide with arready or follow it; capture rdata on rvalid.
  - RD_SUM stores the full word; RD_OVF stores rdata[0].
- Error handling:
  - Any bresp/rresp != 0 sets the err flag and jumps to RESP; remaining phases are skipped.
  - A per-phase counter resets on phase entry; reaching TIMEOUT_CYCLES aborts the same way, with all AXI valids/readys dropped next edge.
- RESP: one-cycle rsp_valid pulse to the owner with rsp_sum, rsp_ovf and rsp_err; then IDLE. rsp_sum/rsp_ovf hold their values until the next RESP.
- No new grant while busy; req_valid held during busy is accepted only in IDLE.
- Latency: with a zero-wait slave, grant-to-rsp_valid is ≤ 12 cycles. Bench checks ordering and the bound, not exact cycles.
- Reset mid-transaction: next edge returns to IDLE with all outputs 0; no rsp emitted; the pending request is dropped (requester must re-request).

Decomposition:
- Package adder_seq_pkg holds:
  - state enum;
  - offsets OFF_OPA=0, OFF_OPB=4, OFF_SUM=8, OFF_OVF=12;
  - RESP_OKAY=0.
- Sub-module rr_arbiter_2: 2-way round-robin grant with last_grant register and one-hot grant output, advanced only on accept.

Test Plan:
- Single request: req0 A=5, B=7 -> write 0x00=5, write 0x04=7, reads 0x08 and 0x0C; rsp_valid=2'b01, sum=12, ovf=0, err=0.
- Overflow: req1 A=0xFFFF_FFFF, B=2 -> rsp_valid=2'b10, sum=0x0000_0001, ovf=1.
- Contention: req0 and req1 asserted in the same cycle, both held -> req0 served first, then req1. Repeat with last_grant=0 -> req1 served first.
- Slave stalls/errors:
  - awready/arready delayed 3 cycles -> valids held stable until handshake;
  - bresp=2 on the WR_B write -> no reads issued, err=1.
- Timeout: slave never asserts arready in RD_SUM -> abort after 255 cycles; arvalid=0; rsp err=1; next request proceeds normally.
- Reset asserted during WR_B -> next edge all AXI valids 0, no rsp pulse; a fresh req0 A=1, B=1 after reset -> sum=2.

Source files
------------

// File: rtl/adder_sequencer_pkg.sv
// rtl/adder_sequencer_pkg.sv - shared types and register map for the adder sequencer
package adder_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        RD_SUM,
        RD_OVF,
        RESP
    } state_e;

    localparam int OFF_OPA   = 0;
    localparam int OFF_OPB   = 4;
    localparam int OFF_SUM   = 8;
    localparam int OFF_OVF   = 12;
    localparam int RESP_OKAY = 0;

endpackage

// File: rtl/adder_sequencer_if.sv
// rtl/adder_sequencer_if.sv - AXI4-Lite bus between the adder sequencer and the adder slave
interface adder_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   m1_axi_awaddr;
    logic                    m1_axi_awvalid;
    logic                    m1_axi_awready;
    logic [DATA_WIDTH-1:0]   m1_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m1_axi_wstrb;
    logic                    m1_axi_wvalid;
    logic                    m1_axi_wready;
    logic [RESP_WIDTH-1:0]   m1_axi_bresp;
    logic                    m1_axi_bvalid;
    logic                    m1_axi_bready;
    logic [ADDR_WIDTH-1:0]   m1_axi_araddr;
    logic                    m1_axi_arvalid;
    logic                    m1_axi_arready;
    logic [DATA_WIDTH-1:0]   m1_axi_rdata;
    logic [RESP_WIDTH-1:0]   m1_axi_rresp;
    logic                    m1_axi_rvalid;
    logic                    m1_axi_rready;

    modport master (
        output m1_axi_awaddr, m1_axi_awvalid, m1_axi_wdata, m1_axi_wstrb, m1_axi_wvalid,
               m1_axi_bready, m1_axi_araddr, m1_axi_arvalid, m1_axi_rready,
        input  m1_axi_awready, m1_axi_wready, m1_axi_bresp, m1_axi_bvalid,
               m1_axi_arready, m1_axi_rdata, m1_axi_rresp, m1_axi_rvalid
    );

    modport slave (
        input  m1_axi_awaddr, m1_axi_awvalid, m1_axi_wdata, m1_axi_wstrb, m1_axi_wvalid,
               m1_axi_bready, m1_axi_araddr, m1_axi_arvalid, m1_axi_rready,
        output m1_axi_awready, m1_axi_wready, m1_axi_bresp, m1_axi_bvalid,
               m1_axi_arready, m1_axi_rdata, m1_axi_rresp, m1_axi_rvalid
    );
endinterface

// File: rtl/adder_sequencer_rr_arbiter_2.sv
// rtl/adder_sequencer_rr_arbiter_2.sv - two-way round-robin arbiter, pointer advances only on accept
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant_q ? 2'b01 : 2'b10;
        end
        last_grant_d = last_grant_q;
        if (accept && (grant != 2'b00)) begin
            last_grant_d = grant[1];
        end
    end

    // Reset to requester 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
endmodule

// File: rtl/adder_sequencer.sv
// rtl/adder_sequencer.sv - AXI4-Lite master running write A, write B, read sum, read overflow per request
module adder_sequencer
    import adder_seq_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int RESP_WIDTH     = 3,
    parameter int BASE_ADDR      = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    m1_axi_aclk,
    input  logic                    m1_axi_aresetn,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_a,
    input  logic [2*DATA_WIDTH-1:0] req_b,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_sum,
    output logic                    rsp_ovf,
    output logic                    rsp_err,
    adder_sequencer_if.master       m1_axi
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] opb_q, opb_d, sum_q, sum_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d, b_done_q, b_done_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic                  arvalid_q, arvalid_d, rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [1:0]            req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic                  rsp_ovf_q, rsp_ovf_d, rsp_err_q, rsp_err_d;

    logic       aw_hs, w_hs, b_hs, ar_hs, r_hs, b_bad, r_bad, tmo, accept;
    logic       abort, finish;
    logic [1:0] grant;

    assign aw_hs  = awvalid_q && m1_axi.m1_axi_awready;
    assign w_hs   = wvalid_q && m1_axi.m1_axi_wready;
    assign b_hs   = bready_q && m1_axi.m1_axi_bvalid;
    assign ar_hs  = arvalid_q && m1_axi.m1_axi_arready;
    assign r_hs   = rready_q && m1_axi.m1_axi_rvalid;
    assign b_bad  = m1_axi.m1_axi_bresp != RESP_WIDTH'(RESP_OKAY);
    assign r_bad  = m1_axi.m1_axi_rresp != RESP_WIDTH'(RESP_OKAY);
    assign tmo    = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
    assign accept = (state_q == IDLE) && (req_valid != 2'b00);

    rr_arbiter_2 u_arb (
        .clk    (m1_axi_aclk),
        .resetn (m1_axi_aresetn),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        opb_d       = opb_q;
        sum_d       = sum_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        b_done_d    = b_done_q;
        cnt_d       = cnt_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        req_ready_d = 2'b00;
        rsp_valid_d = 2'b00;
        rsp_sum_d   = rsp_sum_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_err_d   = rsp_err_q;
        abort       = 1'b0;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_ready_d = grant;
                    owner_d     = grant[1];
                    wdata_d     = grant[1] ? req_a[DATA_WIDTH +: DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
                    opb_d       = grant[1] ? req_b[DATA_WIDTH +: DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
                    sum_d       = '0;
                    awaddr_d    = ADDR_WIDTH'(BASE_ADDR + OFF_OPA);
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    bready_d    = 1'b1;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    b_done_d    = 1'b0;
                    cnt_d       = '0;
                    state_d     = WR_A;
                end
            end
            WR_A, WR_B: begin
                // Address, data and response are tracked independently; any order completes.
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                b_done_d  = b_done_q | b_hs;
                awvalid_d = awvalid_q & ~aw_hs;
                wvalid_d  = wvalid_q & ~w_hs;
                bready_d  = bready_q & ~b_hs;
                cnt_d     = cnt_q + CNT_W'(1);
                if (b_hs && b_bad) begin
                    abort = 1'b1;
                end else if (aw_done_d && w_done_d && b_done_d) begin
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_done_d  = 1'b0;
                    if (state_q == WR_A) begin
                        awaddr_d  = ADDR_WIDTH'(BASE_ADDR + OFF_OPB);
                        wdata_d   = opb_q;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        bready_d  = 1'b1;
                        state_d   = WR_B;
                    end else begin
                        araddr_d  = ADDR_WIDTH'(BASE_ADDR + OFF_SUM);
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = RD_SUM;
                    end
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            RD_SUM, RD_OVF: begin
                arvalid_d = arvalid_q & ~ar_hs;
                cnt_d     = cnt_q + CNT_W'(1);
                if (r_hs && r_bad) begin
                    abort = 1'b1;
                end else if (r_hs) begin
                    cnt_d = '0;
                    if (state_q == RD_SUM) begin
                        sum_d     = m1_axi.m1_axi_rdata;
                        araddr_d  = ADDR_WIDTH'(BASE_ADDR + OFF_OVF);
                        arvalid_d = 1'b1;
                        rready_d  = 1'b1;
                        state_d   = RD_OVF;
                    end else begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b0;
                        rsp_ovf_d = m1_axi.m1_axi_rdata[0];
                        rsp_err_d = 1'b0;
                        finish    = 1'b1;
                    end
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            rsp_ovf_d = 1'b0;
            rsp_err_d = 1'b1;
            finish    = 1'b1;
        end
        // The response pulse is registered on RESP entry so it is high exactly while in RESP.
        if (finish) begin
            state_d     = RESP;
            rsp_valid_d = owner_q ? 2'b10 : 2'b01;
            rsp_sum_d   = sum_q;
        end
    end

    always_ff @(posedge m1_axi_aclk) begin
        if (!m1_axi_aresetn) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            opb_q       <= '0;
            sum_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_done_q    <= 1'b0;
            cnt_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            req_ready_q <= 2'b00;
            rsp_valid_q <= 2'b00;
            rsp_sum_q   <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            opb_q       <= opb_d;
            sum_q       <= sum_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            b_done_q    <= b_done_d;
            cnt_q       <= cnt_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_err   = rsp_err_q;

    assign m1_axi.m1_axi_awaddr  = awaddr_q;
    assign m1_axi.m1_axi_awvalid = awvalid_q;
    assign m1_axi.m1_axi_wdata   = wdata_q;
    assign m1_axi.m1_axi_wstrb   = '1;
    assign m1_axi.m1_axi_wvalid  = wvalid_q;
    assign m1_axi.m1_axi_bready  = bready_q;
    assign m1_axi.m1_axi_araddr  = araddr_q;
    assign m1_axi.m1_axi_arvalid = arvalid_q;
    assign m1_axi.m1_axi_rready  = rready_q;
endmodule

// File: tb/tb_adder_sequencer.sv
// tb/tb_adder_sequencer.sv - directed bench for adder_sequencer with a stallable adder slave
module tb_adder_sequencer;
    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a, req_b;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_sum;
    logic        rsp_ovf, rsp_err;

    int n_checks = 0;
    int n_errors = 0;

    adder_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3)) m1_axi ();

    adder_sequencer #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3), .BASE_ADDR(0), .TIMEOUT_CYCLES(255)
    ) dut (
        .m1_axi_aclk    (clk),
        .m1_axi_aresetn (rstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_sum        (rsp_sum),
        .rsp_ovf        (rsp_ovf),
        .rsp_err        (rsp_err),
        .m1_axi         (m1_axi)
    );

    always #5 clk = ~clk;

    logic [7:0]  awaddr, araddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready, arvalid, rready, awready, arready;
    assign awaddr  = m1_axi.m1_axi_awaddr;
    assign araddr  = m1_axi.m1_axi_araddr;
    assign wdata   = m1_axi.m1_axi_wdata;
    assign wstrb   = m1_axi.m1_axi_wstrb;
    assign awvalid = m1_axi.m1_axi_awvalid;
    assign wvalid  = m1_axi.m1_axi_wvalid;
    assign bready  = m1_axi.m1_axi_bready;
    assign arvalid = m1_axi.m1_axi_arvalid;
    assign rready  = m1_axi.m1_axi_rready;

    // Slave knobs and state
    int          aw_delay, ar_delay;
    logic        ar_never;
    logic [7:0]  berr_addr;
    int          aw_cnt, ar_cnt, aw_stall_last, ar_stall_last;
    logic        have_aw, have_w, s_bvalid, s_rvalid;
    logic [2:0]  s_bresp, s_rresp;
    logic [7:0]  aw_l;
    logic [31:0] w_l, s_rdata, opa_r, opb_r;
    logic [71:0] log_sig = '0;
    int          log_n = 0;

    logic        aw_hs, w_hs, wr_go;
    logic [7:0]  wr_a;
    logic [31:0] wr_d;
    logic [32:0] sum33;

    assign awready = (aw_cnt >= aw_delay);
    assign arready = !ar_never && (ar_cnt >= ar_delay);
    assign m1_axi.m1_axi_awready = awready;
    assign m1_axi.m1_axi_wready  = 1'b1;
    assign m1_axi.m1_axi_arready = arready;
    assign m1_axi.m1_axi_bvalid  = s_bvalid;
    assign m1_axi.m1_axi_bresp   = s_bresp;
    assign m1_axi.m1_axi_rvalid  = s_rvalid;
    assign m1_axi.m1_axi_rresp   = s_rresp;
    assign m1_axi.m1_axi_rdata   = s_rdata;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && 1'b1;
    assign wr_go = (have_aw || aw_hs) && (have_w || w_hs);
    assign wr_a  = aw_hs ? awaddr : aw_l;
    assign wr_d  = w_hs ? wdata : w_l;
    assign sum33 = {1'b0, opa_r} + {1'b0, opb_r};

    always @(posedge clk) begin
        if (!rstn) begin
            aw_cnt <= 0; ar_cnt <= 0; have_aw <= 1'b0; have_w <= 1'b0;
            s_bvalid <= 1'b0; s_bresp <= '0; s_rvalid <= 1'b0; s_rresp <= '0; s_rdata <= '0;
            opa_r <= '0; opb_r <= '0; aw_l <= '0; w_l <= '0;
            aw_stall_last <= 0; ar_stall_last <= 0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
            if (s_bvalid && bready) s_bvalid <= 1'b0;
            if (s_rvalid && rready) s_rvalid <= 1'b0;
            if (aw_hs) begin have_aw <= 1'b1; aw_l <= awaddr; aw_stall_last <= aw_cnt; end
            if (w_hs) begin have_w <= 1'b1; w_l <= wdata; end
            if (wr_go) begin
                if (wr_a == 8'h00) opa_r <= wr_d;
                else if (wr_a == 8'h04) opb_r <= wr_d;
                s_bvalid <= 1'b1;
                s_bresp  <= (wr_a == berr_addr) ? 3'd2 : 3'd0;
                have_aw  <= 1'b0;
                have_w   <= 1'b0;
                log_sig  <= {log_sig[62:0], 1'b1, wr_a};
                log_n    <= log_n + 1;
            end
            if (arvalid && arready) begin
                s_rvalid      <= 1'b1;
                s_rresp       <= 3'd0;
                ar_stall_last <= ar_cnt;
                s_rdata       <= (araddr == 8'h08) ? sum33[31:0] :
                                 (araddr == 8'h0C) ? {31'b0, sum33[32]} : 32'h0;
                log_sig       <= {log_sig[62:0], 1'b0, araddr};
                log_n         <= log_n + 1;
            end
        end
    end

    // Protocol monitor: stalled valids must stay up with a stable address
    logic       pend_aw = 1'b0, pend_ar = 1'b0;
    logic [7:0] pend_awaddr = '0, pend_araddr = '0;
    int         viol = 0, ar_run = 0, ar_run_last = 0, rsp_cnt = 0;

    always @(posedge clk) begin
        if (rsp_valid != 2'b00) rsp_cnt <= rsp_cnt + 1;
        if (!rstn) begin
            pend_aw <= 1'b0; pend_ar <= 1'b0; ar_run <= 0;
        end else begin
            if (pend_aw && (!awvalid || awaddr != pend_awaddr)) viol <= viol + 1;
            if (pend_ar && (!arvalid || araddr != pend_araddr)) viol <= viol + 1;
            pend_aw     <= awvalid && !awready;
            pend_awaddr <= awaddr;
            pend_ar     <= arvalid && !arready;
            pend_araddr <= araddr;
            if (arvalid) ar_run <= ar_run + 1;
            else if (ar_run != 0) begin ar_run_last <= ar_run; ar_run <= 0; end
        end
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input int idx, input logic [31:0] a, input logic [31:0] b);
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_valid[idx]      = 1'b1;
    endtask

    task automatic wait_rsp(output logic [1:0] who, output logic [31:0] s, output logic o,
                            output logic e, output int rl);
        int gnt_at;
        int cyc;
        who = 2'b00; s = '0; o = 1'b0; e = 1'b0; rl = 0; gnt_at = -1; cyc = 0;
        while (who == 2'b00 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (req_ready != 2'b00) begin
                req_valid = req_valid & ~req_ready;
                if (gnt_at < 0) gnt_at = cyc;
            end
            if (rsp_valid != 2'b00) begin
                who = rsp_valid; s = rsp_sum; o = rsp_ovf; e = rsp_err; rl = cyc - gnt_at;
            end
        end
        if (who == 2'b00) chk("rsp_timeout", 1'b0, 1'b1);
    endtask

    logic [1:0]  who;
    logic [31:0] s;
    logic        o, e;
    int          rl, n0, rc0;
    logic        found;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; req_valid = 2'b00; req_a = '0; req_b = '0;
        aw_delay = 0; ar_delay = 0; ar_never = 1'b0; berr_addr = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        chk("rst_axi_valids", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("rst_addr_data", {awaddr, araddr, wdata, rsp_sum}, '0);
        chk("rst_wstrb", wstrb, 4'hF);
        rstn = 1'b1;
        @(negedge clk);

        // Single request on requester 0
        n0 = log_n;
        launch(0, 32'd5, 32'd7);
        wait_rsp(who, s, o, e, rl);
        chk("t1_who", who, 2'b01);
        chk("t1_sum", s, 32'd12);
        chk("t1_ovf_err", {o, e}, 2'b00);
        chk("t1_latency_le12", (rl <= 12), 1'b1);
        chk("t1_nbeats", log_n - n0, 4);
        chk("t1_order", log_sig[35:0], {9'h100, 9'h104, 9'h008, 9'h00C});
        chk("t1_slave_ops", {opa_r, opb_r}, {32'd5, 32'd7});
        @(negedge clk);
        chk("t1_pulse_1cyc", rsp_valid, 2'b00);
        chk("t1_sum_hold", rsp_sum, 32'd12);

        // Overflow on requester 1
        launch(1, 32'hFFFF_FFFF, 32'd2);
        wait_rsp(who, s, o, e, rl);
        chk("t2_who", who, 2'b10);
        chk("t2_sum", s, 32'h0000_0001);
        chk("t2_ovf_err", {o, e}, 2'b10);

        // Contention after last grant to requester 1: requester 0 first
        launch(0, 32'd10, 32'd20);
        launch(1, 32'd100, 32'd200);
        wait_rsp(who, s, o, e, rl);
        chk("t3_first_who", who, 2'b01);
        chk("t3_first_sum", s, 32'd30);
        wait_rsp(who, s, o, e, rl);
        chk("t3_second_who", who, 2'b10);
        chk("t3_second_sum", s, 32'd300);

        // Make requester 0 the last grant, then contend: requester 1 first
        launch(0, 32'd1, 32'd2);
        wait_rsp(who, s, o, e, rl);
        chk("t4_prime_sum", s, 32'd3);
        launch(0, 32'd10, 32'd20);
        launch(1, 32'd100, 32'd200);
        wait_rsp(who, s, o, e, rl);
        chk("t4_first_who", who, 2'b10);
        chk("t4_first_sum", s, 32'd300);
        wait_rsp(who, s, o, e, rl);
        chk("t4_second_who", who, 2'b01);
        chk("t4_second_sum", s, 32'd30);

        // Address-channel stalls of 3 cycles
        aw_delay = 3; ar_delay = 3;
        launch(0, 32'h1234, 32'h1111);
        wait_rsp(who, s, o, e, rl);
        chk("t5_sum", s, 32'h2345);
        chk("t5_err", e, 1'b0);
        chk("t5_aw_stall", aw_stall_last, 3);
        chk("t5_ar_stall", ar_stall_last, 3);
        chk("t5_stable_valids", viol, 0);
        aw_delay = 0; ar_delay = 0;

        // Error response on the operand-B write skips both reads
        berr_addr = 8'h04;
        n0 = log_n;
        launch(1, 32'd4, 32'd4);
        wait_rsp(who, s, o, e, rl);
        chk("t6_who", who, 2'b10);
        chk("t6_err", e, 1'b1);
        chk("t6_no_reads", log_n - n0, 2);
        berr_addr = 8'hFF;

        // Read address never accepted: timeout abort then normal recovery
        ar_never = 1'b1;
        launch(0, 32'd2, 32'd3);
        wait_rsp(who, s, o, e, rl);
        chk("t7_who", who, 2'b01);
        chk("t7_err", e, 1'b1);
        chk("t7_arvalid_dropped", {arvalid, rready}, 2'b00);
        @(negedge clk);
        chk("t7_arvalid_cycles", ar_run_last, 255);
        ar_never = 1'b0;
        launch(0, 32'd2, 32'd3);
        wait_rsp(who, s, o, e, rl);
        chk("t7_recover_sum", s, 32'd5);
        chk("t7_recover_err", e, 1'b0);

        // Reset while the operand-B write is stalled
        aw_delay = 20;
        launch(0, 32'd3, 32'd4);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) req_valid = req_valid & ~req_ready;
            if (awvalid && awaddr == 8'h04) found = 1'b1;
        end
        chk("t8_reached_wr_b", found, 1'b1);
        repeat (2) @(negedge clk);
        rc0 = rsp_cnt;
        rstn = 1'b0;
        @(negedge clk);
        chk("t8_axi_valids_zero", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
        chk("t8_rsp_req_zero", {rsp_valid, req_ready}, 4'b0);
        chk("t8_awaddr_zero", awaddr, 8'h00);
        rstn = 1'b1;
        aw_delay = 0;
        repeat (20) @(negedge clk);
        chk("t8_no_rsp", rsp_cnt - rc0, 0);
        launch(0, 32'd1, 32'd1);
        wait_rsp(who, s, o, e, rl);
        chk("t8_fresh_who", who, 2'b01);
        chk("t8_fresh_sum", s, 32'd2);
        chk("t8_fresh_err", e, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
